pht_updater: RTL and testbench
==============================

Name: pht_updater

Overview:
- Write-side partner of the PHT RAM: takes resolved conditional branches from EX and turns them into 2-bit saturating-counter writes on the PHT write bus, packed as {we, waddr, wdata}.
- After reset it first sweeps every PHT entry to a known state, because the RAM contents are undefined at power-up.
- Buffers updates in a small FIFO. Forwards recent writes so that a stale old_state carried down the pipe never overwrites a newer counter.
- Sits between the EX/branch-resolve stage and the PHT RAM write port.

Parameters:
- PHT_AW, 10, PHT index width (1024 entries)
- PHT_SW, 2, counter state width (fixed at 2; other values unsupported)
- FIFO_DEPTH, 4, update buffer depth, power of 2, >=2
- HIST_N, 2, number of most recent writes kept for forwarding, >=1
- INIT_STATE, 2'b01, value written to every entry by the init sweep (weakly not-taken)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- upd_valid_i  in  1  resolved branch update valid
- upd_ready_o  out  1  updater can accept an update
- upd_index_i  in  PHT_AW  PHT index used at prediction time
- upd_taken_i  in  1  actual branch outcome
- upd_old_state_i  in  PHT_SW  counter value read at prediction time
- wr_stall_i  in  1  PHT write port unavailable this cycle
- w_obus  out  1+PHT_AW+PHT_SW  {we, waddr, wdata} to the PHT write bus
- init_done_o  out  1  init sweep complete

Behaviour:
- Reset (reset=0, async):
  - FIFO and history are cleared.
  - w_obus is forced to 0; init_done_o=0; upd_ready_o=0.
  - The FSM enters INIT with the sweep counter at 0.
  - A reset mid-sweep or mid-update discards all pending updates and restarts the sweep from index 0.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle with wr_stall_i=0, register w_obus={1, cnt, INIT_STATE} and increment cnt.
  - When wr_stall_i=1, drive we=0 and hold cnt.
  - After the write of index 2^PHT_AW-1 is registered, go to RUN and set init_done_o=1 in the same edge.
  - upd_ready_o=0 throughout INIT.
- RUN:
  - upd_ready_o = !fifo_full. This is combinational from registered state and never depends on upd_valid_i.
  - An update is pushed on an edge where upd_valid_i and upd_ready_o are both high.
  - A full FIFO does not accept a same-cycle pass-through, even if a pop happens that cycle.
- Pop: occurs when the FIFO is non-empty and wr_stall_i=0. Entries pop in FIFO order.
- base_state:
  - Equals the newest history entry whose index matches the head entry.
  - The history includes the write being registered on the current w_obus.
  - If no history entry matches, base_state = head.old_state.
- new_state: saturating update of base_state.
  - Taken: +1, saturating at 2'b11.
  - Not taken: -1, saturating at 2'b00.
- On a pop edge:
  - Register w_obus={1, head.index, new_state}.
  - Shift {index, new_state} into the history; the oldest entry drops out.
- Any edge without a pop or init write registers we=0. waddr/wdata are don't-care when we=0.
- Latency:
  - With the FIFO empty and no stall, an update accepted on edge k is popped on edge k+1.
  - we=1 is visible from edge k+1 to edge k+2.
- Simultaneous push and pop to/from a non-full FIFO: both take effect and the count is unchanged.
- Write throughput: one write per cycle.

Optional Feature:
- Macro PHT_UPD_FILTER_EN.
- Defined: when new_state == base_state (counter already saturated in the outcome direction), the entry is popped but we=0 is registered and the history is not updated. This saves RAM write activity.
- Undefined: every pop produces a write, including saturated no-change writes.
- The init sweep is unaffected in both cases.

Decomposition:
- Shared package (extends the existing branch-predictor defines):
  - PHT_AW, PHT_SW, and the write-bus width 1+PHT_AW+PHT_SW.
  - Counter encodings SNT=00, WNT=01, WT=10, ST=11.
  - INIT_STATE.
  - A sat_update(state, taken) function.
- One sub-module is natural: pht_upd_fifo, a synchronous FIFO of {index, taken, old_state} with full/empty outputs and the same async active-low reset.
- The history CAM, FSM and output register stay in the top module.

Test Plan:
- Release reset with no stall -> exactly 1024 writes, addr 0..1023 consecutive, data 01. init_done_o rises with the last write registered. upd_ready_o stays 0 until then.
- After init, push {idx=5, taken=1, old=01} -> two edges later w_obus={1, 5, 10}; one write only.
- Back-to-back pushes {idx=7, taken=1, old=01} twice (stale old) -> writes {7, 10} then {7, 11}, with the second write forwarded from history.
- Push {idx=9, taken=1, old=11} -> with PHT_UPD_FILTER_EN no write occurs; without it, w_obus={1, 9, 11}.
- Hold wr_stall_i=1 and offer 5 updates -> 4 accepted, upd_ready_o low on the 5th. Release the stall -> 4 writes on consecutive cycles in push order.
- Assert reset mid-sweep at cnt=300 and again with 3 queued updates -> w_obus=0 immediately; the sweep restarts at addr 0 and the queued updates are never written.

Source files
------------

// File: rtl/pht_updater_pkg.sv
// pht_updater_pkg
//   Shared definitions for the PHT write side: index/counter widths, the
//   width of the packed {we, waddr, wdata} write bus, the 2-bit counter
//   encodings, the init sweep value, the updater FSM states and the
//   saturating counter update function.
package pht_updater_pkg;

  localparam int PHT_AW     = 10;
  localparam int PHT_SW     = 2;
  localparam int PHT_WBUS_W = 1 + PHT_AW + PHT_SW;

  localparam logic [PHT_SW-1:0] SNT = 2'b00;
  localparam logic [PHT_SW-1:0] WNT = 2'b01;
  localparam logic [PHT_SW-1:0] WT  = 2'b10;
  localparam logic [PHT_SW-1:0] ST  = 2'b11;

  localparam logic [PHT_SW-1:0] INIT_STATE = WNT;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } upd_state_e;

  // Two-bit saturating counter step toward the resolved outcome.
  function automatic logic [PHT_SW-1:0] sat_update(input logic [PHT_SW-1:0] state,
                                                   input logic              taken);
    logic [PHT_SW-1:0] res;
    res = state;
    if (taken) begin
      if (state != ST) res = state + 2'd1;
    end else begin
      if (state != SNT) res = state - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// pht_upd_fifo
//   Synchronous FIFO holding pending PHT updates as packed {index, taken,
//   old_state} words. Push is ignored when full, pop is ignored when empty;
//   a push and a pop in the same cycle both take effect.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-low reset (empties the FIFO)
//   push   - write din this cycle
//   din    - entry to enqueue
//   pop    - retire the head entry this cycle
//   dout   - head entry (valid when !empty)
//   full   - no free slot
//   empty  - no entry stored
module pht_upd_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // One extra wrap bit distinguishes full from empty when the slots match.
  logic [PW:0]  wptr_q;
  logic [PW:0]  rptr_q;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr_q[PW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: nothing is read until the pointers say so.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/pht_updater.sv
// pht_updater
//   Write-side partner of the PHT RAM. After reset it sweeps every entry to
//   INIT_STATE, then converts resolved branches into saturating-counter
//   writes. Updates are buffered in a small FIFO; the last HIST_N writes are
//   kept in a history so a stale old_state never overwrites a newer counter.
//   Optional macro PHT_UPD_FILTER_EN: suppress writes (and history updates)
//   whose new counter equals the base counter.
// Ports:
//   clk             - clock
//   reset           - asynchronous active-low reset
//   upd_valid_i     - resolved branch update valid
//   upd_ready_o     - updater can accept an update (RUN and FIFO not full)
//   upd_index_i     - PHT index used at prediction time
//   upd_taken_i     - actual branch outcome
//   upd_old_state_i - counter value read at prediction time
//   wr_stall_i      - PHT write port unavailable this cycle
//   w_obus          - registered {we, waddr, wdata} to the PHT write bus
//   init_done_o     - init sweep complete
//
// state  | meaning
// S_INIT | sweeping all entries to INIT_STATE, updates not accepted
// S_RUN  | draining buffered updates into counter writes
module pht_updater #(
  parameter int                 PHT_AW     = pht_updater_pkg::PHT_AW,
  parameter int                 PHT_SW     = pht_updater_pkg::PHT_SW,
  parameter int                 FIFO_DEPTH = 4,
  parameter int                 HIST_N     = 2,
  parameter logic [PHT_SW-1:0]  INIT_STATE = pht_updater_pkg::INIT_STATE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     upd_valid_i,
  output logic                     upd_ready_o,
  input  logic [PHT_AW-1:0]        upd_index_i,
  input  logic                     upd_taken_i,
  input  logic [PHT_SW-1:0]        upd_old_state_i,
  input  logic                     wr_stall_i,
  output logic [PHT_AW+PHT_SW:0]   w_obus,
  output logic                     init_done_o
);

  import pht_updater_pkg::*;

  localparam int ENT_W = PHT_AW + 1 + PHT_SW;

  upd_state_e              state_q, state_d;
  logic [PHT_AW-1:0]       cnt_q, cnt_d;
  logic [PHT_AW+PHT_SW:0]  wbus_q, wbus_d;
  logic                    init_done_q, init_done_d;

  logic                    hist_vld_q [HIST_N];
  logic [PHT_AW-1:0]       hist_idx_q [HIST_N];
  logic [PHT_SW-1:0]       hist_st_q  [HIST_N];
  logic                    hist_shift;

  logic                    fifo_full, fifo_empty;
  logic                    push, pop;
  logic [ENT_W-1:0]        head;
  logic [PHT_AW-1:0]       head_idx;
  logic                    head_taken;
  logic [PHT_SW-1:0]       head_old;
  logic [PHT_SW-1:0]       base_state;
  logic [PHT_SW-1:0]       new_state;

  assign upd_ready_o = (state_q == S_RUN) && !fifo_full;
  assign push        = upd_valid_i && upd_ready_o;
  assign w_obus      = wbus_q;
  assign init_done_o = init_done_q;

  pht_upd_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({upd_index_i, upd_taken_i, upd_old_state_i}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_idx, head_taken, head_old} = head;

  // Entry 0 is the newest write (the one currently on w_obus if it was an
  // update), so scanning oldest-to-newest lets the newest match win.
  always_comb begin
    base_state = head_old;
    for (int i = HIST_N - 1; i >= 0; i--) begin
      if (hist_vld_q[i] && (hist_idx_q[i] == head_idx)) base_state = hist_st_q[i];
    end
  end

  assign new_state = sat_update(base_state, head_taken);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    wbus_d      = '0;
    pop         = 1'b0;
    hist_shift  = 1'b0;
    case (state_q)
      S_INIT: begin
        if (!wr_stall_i) begin
          wbus_d = {1'b1, cnt_q, INIT_STATE};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == {PHT_AW{1'b1}}) begin
            state_d     = S_RUN;
            init_done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!fifo_empty && !wr_stall_i) begin
          pop = 1'b1;
`ifdef PHT_UPD_FILTER_EN
          // Counter already saturated in the outcome direction: retire the
          // update without touching the RAM.
          if (new_state != base_state) begin
            wbus_d     = {1'b1, head_idx, new_state};
            hist_shift = 1'b1;
          end
`else
          wbus_d     = {1'b1, head_idx, new_state};
          hist_shift = 1'b1;
`endif
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      wbus_q      <= '0;
      init_done_q <= 1'b0;
      for (int i = 0; i < HIST_N; i++) begin
        hist_vld_q[i] <= 1'b0;
        hist_idx_q[i] <= '0;
        hist_st_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wbus_q      <= wbus_d;
      init_done_q <= init_done_d;
      if (hist_shift) begin
        for (int i = HIST_N - 1; i > 0; i--) begin
          hist_vld_q[i] <= hist_vld_q[i-1];
          hist_idx_q[i] <= hist_idx_q[i-1];
          hist_st_q[i]  <= hist_st_q[i-1];
        end
        hist_vld_q[0] <= 1'b1;
        hist_idx_q[0] <= head_idx;
        hist_st_q[0]  <= new_state;
      end
    end
  end

endmodule

// File: tb/tb_pht_updater.sv
// tb_pht_updater
//   Directed plus randomized stimulus for pht_updater, checked against a
//   queue-based reference model of the updater's behaviour.
module tb_pht_updater;

  localparam int AW    = 10;
  localparam int SW    = 2;
  localparam int DEPTH = 4;
  localparam int HN    = 2;
  localparam int NENT  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          upd_valid_i = 1'b0;
  logic          upd_ready_o;
  logic [AW-1:0] upd_index_i = '0;
  logic          upd_taken_i = 1'b0;
  logic [SW-1:0] upd_old_state_i = '0;
  logic          wr_stall_i = 1'b0;
  logic [AW+SW:0] w_obus;
  logic          init_done_o;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {logic [AW-1:0] idx; logic tk; logic [SW-1:0] old;} upd_t;
  typedef struct packed {logic [AW-1:0] idx; logic [SW-1:0] st;} wr_t;

  upd_t q[$];
  wr_t  hist[$];
  bit   run_m = 1'b0;
  int   init_cnt = 0;

  always #5 clk = ~clk;

  pht_updater #(
    .PHT_AW     (AW),
    .PHT_SW     (SW),
    .FIFO_DEPTH (DEPTH),
    .HIST_N     (HN),
    .INIT_STATE (2'b01)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .upd_valid_i     (upd_valid_i),
    .upd_ready_o     (upd_ready_o),
    .upd_index_i     (upd_index_i),
    .upd_taken_i     (upd_taken_i),
    .upd_old_state_i (upd_old_state_i),
    .wr_stall_i      (wr_stall_i),
    .w_obus          (w_obus),
    .init_done_o     (init_done_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int s, input bit tk);
    if (tk) return (s >= 3) ? 3 : s + 1;
    return (s <= 0) ? 0 : s - 1;
  endfunction

  task automatic model_reset();
    q.delete();
    hist.delete();
    run_m    = 1'b0;
    init_cnt = 0;
  endtask

  // Called just after a falling edge; leaves reset released on a falling edge.
  task automatic do_reset();
    upd_valid_i = 1'b0;
    wr_stall_i  = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("rst_wbus", 32'(w_obus), 0);
    chk("rst_init_done", 32'(init_done_o), 0);
    chk("rst_ready", 32'(upd_ready_o), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Sweep until stop_at entries have been written (or the budget expires).
  task automatic run_init(input int stop_at, input bit rnd_stall);
    int budget;
    bit st;
    budget = 0;
    while (init_cnt < stop_at && budget < 4000) begin
      st = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      wr_stall_i      = st;
      upd_valid_i     = 1'($urandom_range(0, 1));
      upd_index_i     = AW'($urandom_range(0, NENT - 1));
      upd_taken_i     = 1'($urandom_range(0, 1));
      upd_old_state_i = SW'($urandom_range(0, 3));
      #1;
      chk("init_ready", 32'(upd_ready_o), 0);
      @(posedge clk);
      #1;
      chk("init_we", 32'(w_obus[AW+SW]), 32'(!st));
      if (!st) begin
        chk("init_addr", 32'(w_obus[AW+SW-1:SW]), 32'(init_cnt));
        chk("init_data", 32'(w_obus[SW-1:0]), 1);
        init_cnt++;
        if (init_cnt == NENT) run_m = 1'b1;
      end
      chk("init_done", 32'(init_done_o), 32'(run_m));
      @(negedge clk);
      budget++;
    end
    if (init_cnt < stop_at) chk("init_timeout", 32'(init_cnt), 32'(stop_at));
    upd_valid_i = 1'b0;
    wr_stall_i  = 1'b0;
  endtask

  // One RUN-phase clock: drive inputs, predict the edge, check the result.
  task automatic drive_cycle(input bit v, input logic [AW-1:0] idx, input bit tk,
                             input logic [SW-1:0] old, input bit st, output bit acc);
    bit exp_ready, exp_we;
    int base, nxt;
    upd_t e;
    wr_t  w;
    upd_valid_i     = v;
    upd_index_i     = idx;
    upd_taken_i     = tk;
    upd_old_state_i = old;
    wr_stall_i      = st;
    #1;
    exp_ready = run_m && (q.size() < DEPTH);
    chk("ready", 32'(upd_ready_o), 32'(exp_ready));
    exp_we = 1'b0;
    w      = '0;
    if (run_m && q.size() > 0 && !st) begin
      e    = q.pop_front();
      base = int'(e.old);
      for (int i = hist.size() - 1; i >= 0; i--)
        if (hist[i].idx == e.idx) base = int'(hist[i].st);
      nxt    = sat(base, e.tk);
      exp_we = 1'b1;
`ifdef PHT_UPD_FILTER_EN
      if (nxt == base) exp_we = 1'b0;
`endif
      if (exp_we) begin
        w.idx = e.idx;
        w.st  = SW'(nxt);
        hist.push_front(w);
        if (hist.size() > HN) void'(hist.pop_back());
      end
    end
    acc = v && exp_ready;
    if (acc) begin
      e.idx = idx; e.tk = tk; e.old = old;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("we", 32'(w_obus[AW+SW]), 32'(exp_we));
    if (exp_we) begin
      chk("waddr", 32'(w_obus[AW+SW-1:SW]), 32'(w.idx));
      chk("wdata", 32'(w_obus[SW-1:0]), 32'(w.st));
    end
    chk("init_done_run", 32'(init_done_o), 32'(run_m));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, '0, 1'b0, acc);
  endtask

  initial begin
    bit acc;
    upd_t pend [5];

    do_reset();
    run_init(NENT, 1'b0);
    idle(2);

    // Single update: write two edges after the offer.
    drive_cycle(1'b1, 10'd5, 1'b1, 2'b01, 1'b0, acc);
    idle(3);

    // Same index twice with a stale old_state: second must forward.
    drive_cycle(1'b1, 10'd7, 1'b1, 2'b01, 1'b0, acc);
    drive_cycle(1'b1, 10'd7, 1'b1, 2'b01, 1'b0, acc);
    idle(3);

    // Already-saturated counter.
    drive_cycle(1'b1, 10'd9, 1'b1, 2'b11, 1'b0, acc);
    idle(3);

    // Stalled write port: four fit, the fifth is refused until space frees.
    for (int i = 0; i < 5; i++) begin
      pend[i].idx = AW'($urandom_range(100, 200));
      pend[i].tk  = 1'($urandom_range(0, 1));
      pend[i].old = SW'($urandom_range(0, 3));
    end
    for (int i = 0; i < 5; i++)
      drive_cycle(1'b1, pend[i].idx, pend[i].tk, pend[i].old, 1'b1, acc);
    idle(6);

    // Random traffic over a few indices to exercise forwarding.
    for (int i = 0; i < 400; i++)
      drive_cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), SW'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0), acc);
    idle(6);

    // Reset with three updates queued behind a stall.
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, AW'(20 + i), 1'b1, 2'b10, 1'b1, acc);
    do_reset();
    run_init(NENT, 1'b1);
    idle(4);

    // Reset in the middle of the sweep.
    do_reset();
    run_init(300, 1'b0);
    do_reset();
    run_init(NENT, 1'b1);
    drive_cycle(1'b1, 10'd5, 1'b0, 2'b01, 1'b0, acc);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
